// File: rtl/pmt_conditioner.sv
// Two-channel PMT front end: synchronise, one hit per pulse with deadtime and re-arm-on-low,
// saturating drop counters. Optional coincidence flag under `PMT_COINC_VETO_EN.
module pmt_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 8,
  parameter int DROPW       = 16
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             pin,
  input  logic             mask,
  input  logic             clrcnt,
  output logic             hit_nxt,
  output logic [DROPW-1:0] dropcnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, WAITLOW = 2'd2} state_t;

  localparam logic [7:0]       DT  = 8'(DEADTIME);
  localparam logic [DROPW-1:0] ONE = DROPW'(1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync, prev, drop;
  state_t                 state, state_nxt;
  logic [7:0]             dcnt, dcnt_nxt;

  assign sync = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
      state     <= IDLE;
      dcnt      <= '0;
      dropcnt   <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin};
      prev      <= sync;
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      if (clrcnt)
        dropcnt <= '0;
      else if (drop && (dropcnt != {DROPW{1'b1}}))
        dropcnt <= dropcnt + ONE;
    end
  end

  // DEAD spans DEADTIME+1 cycles (exit is taken on the cycle the counter reads 0),
  // giving a minimum hit spacing of DEADTIME+2.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    hit_nxt   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (sync) begin
        hit_nxt   = ~mask;
        dcnt_nxt  = DT;
        state_nxt = (DEADTIME == 0) ? WAITLOW : DEAD;
      end
      DEAD: begin
        drop = sync & ~prev;
        if (dcnt == 8'd0) state_nxt = sync ? WAITLOW : IDLE;
        else              dcnt_nxt  = dcnt - 8'd1;
      end
      WAITLOW: if (!sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module pmt_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 8,
  parameter int DROPW       = 16
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic [1:0]       pmtin,
  input  logic [1:0]       mask,
  input  logic             clrcnt,
  output logic [1:0]       buffer,
  output logic [DROPW-1:0] dropcnt0,
  output logic [DROPW-1:0] dropcnt1,
  output logic             vetopmtlast
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            hit_nxt;
  logic [NUM_LANES-1:0][DROPW-1:0] dcnt;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
      pmt_chan #(.SYNC_STAGES(SYNC_STAGES), .DEADTIME(DEADTIME), .DROPW(DROPW)) u_chan (
        .clkin   (clkin),
        .resetn  (resetn),
        .pin     (pmtin[i]),
        .mask    (mask[i]),
        .clrcnt  (clrcnt),
        .hit_nxt (hit_nxt[i]),
        .dropcnt (dcnt[i])
      );
    end
  endgenerate

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) buffer <= '0;
    else         buffer <= hit_nxt;
  end

  assign dropcnt0 = dcnt[0];
  assign dropcnt1 = dcnt[1];

`ifdef PMT_COINC_VETO_EN
  // hit_nxt is already mask-gated, so only unmasked coincidences flag.
  logic veto;
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) veto <= 1'b0;
    else         veto <= &hit_nxt;
  end
  assign vetopmtlast = veto;
`else
  assign vetopmtlast = 1'b0;
`endif
endmodule

// File: tb/tb_pmt_conditioner.sv
// Directed bench for pmt_conditioner: default instance plus a DROPW=4 instance for saturation.
module tb_pmt_conditioner;
`ifdef PMT_COINC_VETO_EN
  localparam int VETO_EXP = 1;
`else
  localparam int VETO_EXP = 0;
`endif

  logic        clkin = 1'b0;
  logic        resetn;
  logic [1:0]  pmtin, mask;
  logic        clrcnt;
  logic [1:0]  buffer, buffer4;
  logic [15:0] dropcnt0, dropcnt1;
  logic [3:0]  d4_0, d4_1;
  logic        vetopmtlast, veto4;

  int checks = 0, passed = 0;
  int hcnt[2], first[2], second[2];
  int vcnt;

  always #5 clkin = ~clkin;

  pmt_conditioner dut (
    .clkin(clkin), .resetn(resetn), .pmtin(pmtin), .mask(mask), .clrcnt(clrcnt),
    .buffer(buffer), .dropcnt0(dropcnt0), .dropcnt1(dropcnt1), .vetopmtlast(vetopmtlast)
  );

  pmt_conditioner #(.DROPW(4)) dut4 (
    .clkin(clkin), .resetn(resetn), .pmtin(pmtin), .mask(mask), .clrcnt(clrcnt),
    .buffer(buffer4), .dropcnt0(d4_0), .dropcnt1(d4_1), .vetopmtlast(veto4)
  );

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic settle();
    pmtin = 2'b00;
    repeat (15) tick();
  endtask

  task automatic clear();
    clrcnt = 1'b1;
    tick();
    clrcnt = 1'b0;
  endtask

  // Bit k of p0/p1 is driven just before tick k+1; hits are logged by tick number.
  task automatic run(input logic [127:0] p0, input logic [127:0] p1, input int n);
    for (int c = 0; c < 2; c++) begin
      hcnt[c] = 0; first[c] = -1; second[c] = -1;
    end
    vcnt = 0;
    for (int k = 0; k < n; k++) begin
      pmtin = {p1[k], p0[k]};
      tick();
      for (int c = 0; c < 2; c++) if (buffer[c]) begin
        if (hcnt[c] == 0) first[c] = k + 1;
        else if (hcnt[c] == 1) second[c] = k + 1;
        hcnt[c]++;
      end
      if (vetopmtlast) vcnt++;
    end
    pmtin = 2'b00;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pmtin = 2'b11; mask = 2'b00; clrcnt = 1'b0;
    repeat (5) tick();
    checks++; if (buffer !== 2'b00) $display("FAIL rst_buffer: got %b exp 00", buffer); else passed++;
    checks++; if (dropcnt0 !== 16'd0) $display("FAIL rst_drop0: got %0d exp 0", dropcnt0); else passed++;
    checks++; if (dropcnt1 !== 16'd0) $display("FAIL rst_drop1: got %0d exp 0", dropcnt1); else passed++;
    resetn = 1'b1;
    tick(); tick();
    checks++; if (buffer !== 2'b00) $display("FAIL rst_early: got %b exp 00", buffer); else passed++;
    tick();
    checks++; if (buffer !== 2'b11) $display("FAIL rst_first_hit: got %b exp 11", buffer); else passed++;
    checks++; if (vetopmtlast !== 1'(VETO_EXP)) $display("FAIL rst_veto: got %b exp %0d", vetopmtlast, VETO_EXP); else passed++;
    tick();
    checks++; if (buffer !== 2'b00) $display("FAIL rst_one_cycle: got %b exp 00", buffer); else passed++;
    settle();
  endtask

  task automatic test_single_pulse();
    logic [127:0] p = '0;
    for (int k = 0; k < 20; k++) p[k] = 1'b1;
    clear();
    run(p, '0, 35);
    checks++; if (hcnt[0] !== 1) $display("FAIL single_hits: got %0d exp 1", hcnt[0]); else passed++;
    checks++; if (first[0] !== 3) $display("FAIL single_latency: got %0d exp 3", first[0]); else passed++;
    checks++; if (hcnt[1] !== 0) $display("FAIL single_ch1: got %0d exp 0", hcnt[1]); else passed++;
    checks++; if (dropcnt0 !== 16'd0) $display("FAIL single_drop: got %0d exp 0", dropcnt0); else passed++;
    settle();
  endtask

  task automatic test_deadtime_drop();
    logic [127:0] p = '0;
    for (int k = 0; k < 40; k++) p[k] = ((k % 4) < 2);
    clear();
    run(p, '0, 55);
    checks++; if (hcnt[0] !== 4) $display("FAIL dead_hits: got %0d exp 4", hcnt[0]); else passed++;
    checks++; if (first[0] !== 3) $display("FAIL dead_first: got %0d exp 3", first[0]); else passed++;
    checks++; if (second[0] !== 15) $display("FAIL dead_second: got %0d exp 15", second[0]); else passed++;
    checks++; if (dropcnt0 !== 16'd6) $display("FAIL dead_drops: got %0d exp 6", dropcnt0); else passed++;
    settle();
  endtask

  task automatic test_min_spacing();
    logic [127:0] p = '0;
    p[0] = 1'b1; p[10] = 1'b1;
    clear();
    run(p, '0, 30);
    checks++; if (hcnt[0] !== 2) $display("FAIL space_hits: got %0d exp 2", hcnt[0]); else passed++;
    checks++; if (second[0] !== 13) $display("FAIL space_second: got %0d exp 13", second[0]); else passed++;
    checks++; if (dropcnt0 !== 16'd0) $display("FAIL space_drop: got %0d exp 0", dropcnt0); else passed++;
    settle();
    // Rising edge on the final DEAD cycle: dropped, then held high -> WAITLOW, no hit.
    p = '0; p[0] = 1'b1;
    for (int k = 9; k < 15; k++) p[k] = 1'b1;
    clear();
    run(p, '0, 35);
    checks++; if (hcnt[0] !== 1) $display("FAIL edge_hits: got %0d exp 1", hcnt[0]); else passed++;
    checks++; if (dropcnt0 !== 16'd1) $display("FAIL edge_drop: got %0d exp 1", dropcnt0); else passed++;
    settle();
  endtask

  task automatic test_sat_clear();
    logic [127:0] p = '0;
    for (int k = 0; k < 60; k += 2) p[k] = 1'b1;
    clear();
    run(p, '0, 75);
    checks++; if (hcnt[0] !== 6) $display("FAIL sat_hits: got %0d exp 6", hcnt[0]); else passed++;
    checks++; if (dropcnt0 !== 16'd24) $display("FAIL sat_wide: got %0d exp 24", dropcnt0); else passed++;
    checks++; if (d4_0 !== 4'd15) $display("FAIL sat_narrow: got %0d exp 15", d4_0); else passed++;
    // Drops land on ticks 5 and 7; clrcnt coincides with the first.
    for (int k = 0; k < 10; k++) begin
      pmtin = {1'b0, 1'((k % 2) == 0)};
      clrcnt = (k == 4);
      tick();
      if (k == 4) begin
        checks++; if (dropcnt0 !== 16'd0) $display("FAIL clr_wide: got %0d exp 0", dropcnt0); else passed++;
        checks++; if (d4_0 !== 4'd0) $display("FAIL clr_narrow: got %0d exp 0", d4_0); else passed++;
      end
      if (k == 6) begin
        checks++; if (dropcnt0 !== 16'd1) $display("FAIL clr_after: got %0d exp 1", dropcnt0); else passed++;
      end
    end
    clrcnt = 1'b0;
    settle();
  endtask

  task automatic test_mask();
    logic [127:0] p = '0;
    p[0] = 1'b1; p[2] = 1'b1;
    mask = 2'b01;
    clear();
    run(p, p, 20);
    checks++; if (hcnt[0] !== 0) $display("FAIL mask_ch0: got %0d exp 0", hcnt[0]); else passed++;
    checks++; if (hcnt[1] !== 1) $display("FAIL mask_ch1: got %0d exp 1", hcnt[1]); else passed++;
    checks++; if (first[1] !== 3) $display("FAIL mask_lat1: got %0d exp 3", first[1]); else passed++;
    checks++; if (dropcnt0 !== 16'd1) $display("FAIL mask_drop0: got %0d exp 1", dropcnt0); else passed++;
    checks++; if (dropcnt1 !== 16'd1) $display("FAIL mask_drop1: got %0d exp 1", dropcnt1); else passed++;
    checks++; if (vcnt !== 0) $display("FAIL mask_veto: got %0d exp 0", vcnt); else passed++;
    mask = 2'b00;
    settle();
  endtask

  task automatic test_coinc();
    logic [127:0] p0 = '0, p1 = '0;
    p0[0] = 1'b1; p1[0] = 1'b1;
    run(p0, p1, 15);
    checks++; if (first[0] !== 3) $display("FAIL coinc_lat0: got %0d exp 3", first[0]); else passed++;
    checks++; if (first[1] !== 3) $display("FAIL coinc_lat1: got %0d exp 3", first[1]); else passed++;
    checks++; if (vcnt !== VETO_EXP) $display("FAIL coinc_veto: got %0d exp %0d", vcnt, VETO_EXP); else passed++;
    settle();
    p1 = '0; p1[1] = 1'b1;
    run(p0, p1, 15);
    checks++; if (first[0] !== 3) $display("FAIL offset_lat0: got %0d exp 3", first[0]); else passed++;
    checks++; if (first[1] !== 4) $display("FAIL offset_lat1: got %0d exp 4", first[1]); else passed++;
    checks++; if (vcnt !== 0) $display("FAIL offset_veto: got %0d exp 0", vcnt); else passed++;
    settle();
  endtask

  initial begin
    resetn = 1'b0; pmtin = 2'b00; mask = 2'b00; clrcnt = 1'b0;
    test_reset();
    test_single_pulse();
    test_deadtime_drop();
    test_min_spacing();
    test_sat_clear();
    test_mask();
    test_coinc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
